// File: rtl/bs_window_buffer.sv
// Circular bitstream window buffer feeding the H.264 syntax parser.
// Holds DEPTH 32-bit stream words and presents 48 bits starting at the parser bit pointer.
module bs_window_buffer #(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] word_in,
   input  logic        word_valid,
   output logic        word_ready,
   input  logic [31:0] pc,
   output logic [15:0] BitStream_buffer_output,
   output logic [31:0] BitStream_buffer_output_ex32,
   output logic        window_valid,
   output logic        pc_underflow
);

   localparam int AW = $clog2(DEPTH);

   logic [26:0] wr_idx_reg;
   logic [26:0] base_reg;
   logic [31:0] mem [DEPTH];

   logic [26:0]   w_idx;
   logic [4:0]    bit_off;
   logic          skip;
   logic [26:0]   occ;
   logic          accept;
   logic          underflow;
   logic          valid_next;
   logic [AW-1:0] slot_addr [3];
   logic [31:0]   win_word  [3];
   logic [95:0]   window96;
   logic [47:0]   out48;

   assign w_idx   = pc[31:5];
   assign bit_off = pc[4:0];

   // Skip mode: the parser has moved past words not yet received.
   assign skip       = wr_idx_reg < base_reg;
   assign occ        = skip ? '0 : (wr_idx_reg - base_reg);
   assign word_ready = !reset && (occ < 27'(DEPTH));
   assign accept     = word_valid && word_ready;

   assign underflow  = w_idx < base_reg;
   assign valid_next = (wr_idx_reg >= (w_idx + 27'd3)) && !underflow;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_slot
         assign slot_addr[gi] = w_idx[AW-1:0] + AW'(gi);
         assign win_word[gi]  = mem[slot_addr[gi]];
      end
   endgenerate

   // MSB of window96 is stream bit 32*w; stream bit pc+i sits at index 95-bit_off-i.
   assign window96 = {win_word[0], win_word[1], win_word[2]};
   assign out48    = window96[7'd48 - 7'(bit_off) +: 48];

   always_ff @(posedge clk) begin
      if (accept && !skip) begin
         mem[wr_idx_reg[AW-1:0]] <= word_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_idx_reg                   <= '0;
         base_reg                     <= '0;
         BitStream_buffer_output      <= '0;
         BitStream_buffer_output_ex32 <= '0;
         window_valid                 <= 1'b0;
         pc_underflow                 <= 1'b0;
      end else begin
         base_reg <= w_idx;
         if (accept) begin
            wr_idx_reg <= wr_idx_reg + 27'd1;
         end
         if (underflow) begin
            pc_underflow <= 1'b1;
            window_valid <= 1'b0;
         end else begin
            window_valid <= valid_next;
            if (valid_next) begin
               BitStream_buffer_output      <= out48[47:32];
               BitStream_buffer_output_ex32 <= out48[31:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_bs_window_buffer.sv
// Randomized scoreboard bench for bs_window_buffer with a bit-level stream reference model.
module tb_bs_window_buffer;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] word_in = '0;
   logic        word_valid = 1'b0;
   logic        word_ready;
   logic [31:0] pc = '0;
   logic [15:0] BitStream_buffer_output;
   logic [31:0] BitStream_buffer_output_ex32;
   logic        window_valid;
   logic        pc_underflow;

   always #5 clk = ~clk;

   bs_window_buffer #(.DEPTH(DEPTH)) dut (
      .clk                          (clk),
      .reset                        (reset),
      .word_in                      (word_in),
      .word_valid                   (word_valid),
      .word_ready                   (word_ready),
      .pc                           (pc),
      .BitStream_buffer_output      (BitStream_buffer_output),
      .BitStream_buffer_output_ex32 (BitStream_buffer_output_ex32),
      .window_valid                 (window_valid),
      .pc_underflow                 (pc_underflow)
   );

   int n_vec = 0;
   int n_err = 0;

   // word source
   logic [31:0] src_words [0:511];
   int          src_idx = 0;
   int          src_len = 0;
   bit          src_on  = 1'b0;
   int          vld_pct = 100;

   // reference model: every accepted word by absolute stream index
   logic [31:0] stream_mem [0:1023];
   longint      m_acc  = 0;
   longint      m_base = 0;
   logic        m_v    = 1'b0;
   logic        m_uf   = 1'b0;
   logic [15:0] m_o16  = '0;
   logic [31:0] m_o32  = '0;

   typedef struct {
      logic        v;
      logic        uf;
      logic [15:0] o16;
      logic [31:0] o32;
   } exp_t;
   exp_t sb_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      longint w;
      longint occ;
      longint p;
      int     widx;
      int     bpos;
      logic [31:0] wd;
      exp_t   e;
      if (reset) begin
         m_acc = 0; m_base = 0; m_v = 1'b0; m_uf = 1'b0; m_o16 = '0; m_o32 = '0;
      end else begin
         w   = longint'(pc >> 5);
         occ = (m_acc >= m_base) ? (m_acc - m_base) : 0;
         if (w < m_base) begin
            m_uf = 1'b1;
            m_v  = 1'b0;
         end else if (m_acc >= w + 3) begin
            m_v = 1'b1;
            for (int i = 0; i < 48; i++) begin
               p    = longint'(pc) + i;
               widx = int'((p / 32) % 1024);
               bpos = 31 - int'(p % 32);
               wd   = stream_mem[widx];
               if (i < 16) m_o16[15-i] = wd[bpos];
               else        m_o32[31-(i-16)] = wd[bpos];
            end
         end else begin
            m_v = 1'b0;
         end
         if (word_valid && occ < DEPTH) begin
            stream_mem[int'(m_acc % 1024)] = word_in;
            m_acc++;
         end
         m_base = w;
      end
      e.v = m_v; e.uf = m_uf; e.o16 = m_o16; e.o32 = m_o32;
      sb_q.push_back(e);
   end

   always @(negedge clk) begin
      exp_t   e;
      longint occ;
      if (sb_q.size() > 0) begin
         e   = sb_q.pop_front();
         occ = (m_acc >= m_base) ? (m_acc - m_base) : 0;
         check("window_valid", 32'(window_valid), 32'(e.v));
         check("pc_underflow", 32'(pc_underflow), 32'(e.uf));
         check("out16", 32'(BitStream_buffer_output), 32'(e.o16));
         check("out_ex32", BitStream_buffer_output_ex32, e.o32);
         check("word_ready", 32'(word_ready), 32'(!reset && occ < DEPTH));
      end
   end

   task automatic drive_src();
      word_valid = src_on && (src_idx < src_len) && (int'($urandom_range(0, 99)) < vld_pct);
      word_in    = (src_idx < src_len) ? src_words[src_idx] : 32'h0;
   endtask

   task automatic step();
      logic rdy;
      @(negedge clk);
      rdy = word_ready;
      @(posedge clk);
      if (word_valid && rdy) src_idx++;
      #1;
      drive_src();
   endtask

   task automatic wait_idx(input int target, input int budget, input string name);
      int n = 0;
      while (src_idx < target && n < budget) begin
         step();
         n++;
      end
      check(name, 32'(src_idx), 32'(target));
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      src_idx = 0;
      drive_src();
      step();
      reset = 1'b0;
   endtask

   task automatic load_basic();
      src_words[0] = 32'h00000001;
      src_words[1] = 32'h80000000;
      src_words[2] = 32'hFFFF0000;
      src_words[3] = 32'h12345678;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) step();
      check("reset_out16", 32'(BitStream_buffer_output), 32'h0);
      check("reset_valid", 32'(window_valid), 32'h0);
      reset = 1'b0;

      // basic fill and fetch, then unaligned pointer
      load_basic();
      src_len = 4; src_on = 1'b1; vld_pct = 100; pc = 0;
      drive_src();
      wait_idx(3, 20, "basic_fill_count");
      step();
      check("basic_valid", 32'(window_valid), 32'h1);
      check("basic_out16", 32'(BitStream_buffer_output), 32'h0000);
      check("basic_ex32", BitStream_buffer_output_ex32, 32'h00018000);
      pc = 31;
      step();
      check("unaligned_out16", 32'(BitStream_buffer_output), 32'hC000);

      // full back-pressure
      for (int i = 0; i < 20; i++) src_words[i] = $urandom;
      src_len = 20; pc = 0;
      do_reset();
      repeat (20) step();
      check("full_accepts", 32'(src_idx), 32'd8);
      check("full_ready_low", 32'(word_ready), 32'h0);
      pc = 32;
      repeat (10) step();
      check("full_after_free", 32'(src_idx), 32'd9);

      // skip mode
      for (int i = 0; i < 14; i++) src_words[i] = $urandom;
      src_len = 14; pc = 320;
      do_reset();
      wait_idx(13, 60, "skip_fill_count");
      step();
      check("skip_valid", 32'(window_valid), 32'h1);
      check("skip_out16", 32'(BitStream_buffer_output), 32'(src_words[10][31:16]));
      check("skip_ex32", BitStream_buffer_output_ex32, {src_words[10][15:0], src_words[11][31:16]});

      // underflow
      load_basic();
      src_len = 4; pc = 0;
      do_reset();
      wait_idx(4, 20, "uf_fill_count");
      src_on = 1'b0;
      drive_src();
      pc = 96;
      repeat (2) step();
      pc = 0;
      step();
      check("uf_set", 32'(pc_underflow), 32'h1);
      check("uf_valid_low", 32'(window_valid), 32'h0);
      repeat (4) step();
      check("uf_sticky", 32'(pc_underflow), 32'h1);
      do_reset();
      check("uf_cleared", 32'(pc_underflow), 32'h0);

      // reset mid-stream with occ = 5
      load_basic();
      for (int i = 4; i < 12; i++) src_words[i] = $urandom;
      src_len = 12; src_on = 1'b1; pc = 0;
      do_reset();
      wait_idx(5, 20, "mid_fill_count");
      check("mid_word_valid", 32'(word_valid), 32'h1);
      reset   = 1'b1;
      src_idx = 0;
      drive_src();
      step();
      check("mid_ready_in_reset", 32'(word_ready), 32'h0);
      check("mid_out16_zero", 32'(BitStream_buffer_output), 32'h0);
      check("mid_ex32_zero", BitStream_buffer_output_ex32, 32'h0);
      check("mid_valid_zero", 32'(window_valid), 32'h0);
      reset = 1'b0;
      wait_idx(3, 20, "refill_count");
      step();
      check("refill_valid", 32'(window_valid), 32'h1);
      check("refill_out16", 32'(BitStream_buffer_output), 32'h0000);
      check("refill_ex32", BitStream_buffer_output_ex32, 32'h00018000);

      // randomized streaming with a stalling parser
      for (int i = 0; i < 300; i++) src_words[i] = $urandom;
      src_len = 300; vld_pct = 70; pc = 0;
      do_reset();
      for (int c = 0; c < 700; c++) begin
         step();
         if (window_valid && ($urandom_range(0, 3) != 0)) pc = pc + $urandom_range(0, 40);
      end

      src_on = 1'b0;
      drive_src();
      repeat (3) step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
